// File: rtl/rvvi_frame_buffer.sv
// rtl/rvvi_frame_buffer.sv - store-and-forward word FIFO from the RVVI packetizer to the MAC transmit stream
// Frames are released only once their last word is stored; frames larger than the buffer are dropped and counted.
module rvvi_frame_buffer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          InAxiWdata,
    input  logic [3:0]           InAxiWstrb,
    input  logic                 InAxiWlast,
    input  logic                 InAxiWvalid,
    output logic                 InAxiWready,
    output logic [31:0]          OutAxisTdata,
    output logic [3:0]           OutAxisTkeep,
    output logic                 OutAxisTlast,
    output logic                 OutAxisTvalid,
    input  logic                 OutAxisTready,
    output logic [CNT_WIDTH-1:0] FramesPending,
    output logic [CNT_WIDTH-1:0] FramesSent,
    output logic [CNT_WIDTH-1:0] FramesDropped
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_ACCEPT = 1'b0,
        S_DROP   = 1'b1
    } wr_state_t;

    wr_state_t r_state;
    wr_state_t w_state_nxt;

    // Stored word layout: {data[31:0], strb[3:0], last}
    logic [36:0]          r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_commit_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_fetch_ptr;
    logic                 r_pf_valid;
    logic [36:0]          r_pf_word;
    logic                 r_out_valid;
    logic [36:0]          r_out_word;
    logic [CNT_WIDTH-1:0] r_frames_pending;
    logic [CNT_WIDTH-1:0] r_frames_sent;
    logic [CNT_WIDTH-1:0] r_frames_dropped;

    logic [PW-1:0] w_occ;
    logic          w_full;
    logic          w_drop_start;
    logic          w_wr_acc;
    logic          w_wr_store;
    logic          w_commit;
    logic          w_drop_done;
    logic          w_out_xfer;
    logic          w_pf_to_out;
    logic          w_fetch;
    logic          w_sent_last;

    // RdPtr only advances on an output transfer, so words held in the
    // prefetch/output registers still count toward occupancy.
    assign w_occ  = r_wr_ptr - r_rd_ptr;
    assign w_full = (w_occ == PW'(DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        InAxiWready  = 1'b0;
        w_drop_start = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                InAxiWready = ~w_full;
                if (w_full && (r_commit_ptr == r_rd_ptr)) begin
                    w_drop_start = 1'b1;
                    w_state_nxt  = S_DROP;
                end
            end
            S_DROP: begin
                InAxiWready = 1'b1;
                if (InAxiWvalid && InAxiWlast) begin
                    w_state_nxt = S_ACCEPT;
                end
            end
            default: w_state_nxt = S_ACCEPT;
        endcase
    end

    assign w_wr_acc    = InAxiWvalid & InAxiWready;
    assign w_wr_store  = w_wr_acc & (r_state == S_ACCEPT);
    assign w_commit    = w_wr_store & InAxiWlast;
    assign w_drop_done = w_wr_acc & (r_state == S_DROP) & InAxiWlast;

    assign w_out_xfer  = r_out_valid & OutAxisTready;
    assign w_pf_to_out = r_pf_valid & (~r_out_valid | OutAxisTready);
    assign w_fetch     = (r_fetch_ptr != r_commit_ptr) & (~r_pf_valid | w_pf_to_out);
    assign w_sent_last = w_out_xfer & r_out_word[0];

    always_ff @(posedge clk) begin
        if (!reset && w_wr_store) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {InAxiWdata, InAxiWstrb, InAxiWlast};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_ACCEPT;
            r_wr_ptr         <= '0;
            r_commit_ptr     <= '0;
            r_rd_ptr         <= '0;
            r_fetch_ptr      <= '0;
            r_pf_valid       <= 1'b0;
            r_pf_word        <= '0;
            r_out_valid      <= 1'b0;
            r_out_word       <= '0;
            r_frames_pending <= '0;
            r_frames_sent    <= '0;
            r_frames_dropped <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_drop_start) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + PW'(1);
            end

            if (w_out_xfer) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + PW'(1);
                r_pf_valid  <= 1'b1;
                r_pf_word   <= r_mem[r_fetch_ptr[DEPTH_LOG2-1:0]];
            end else if (w_pf_to_out) begin
                r_pf_valid <= 1'b0;
            end

            if (w_pf_to_out) begin
                r_out_valid <= 1'b1;
                r_out_word  <= r_pf_word;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            case ({w_commit, w_sent_last})
                2'b10:   r_frames_pending <= r_frames_pending + CNT_WIDTH'(1);
                2'b01:   r_frames_pending <= r_frames_pending - CNT_WIDTH'(1);
                default: r_frames_pending <= r_frames_pending;
            endcase

            if (w_sent_last) begin
                r_frames_sent <= r_frames_sent + CNT_WIDTH'(1);
            end
            if (w_drop_done) begin
                r_frames_dropped <= r_frames_dropped + CNT_WIDTH'(1);
            end
        end
    end

    assign OutAxisTvalid = r_out_valid;
    assign OutAxisTdata  = r_out_word[36:5];
    assign OutAxisTkeep  = r_out_word[4:1];
    assign OutAxisTlast  = r_out_word[0];
    assign FramesPending = r_frames_pending;
    assign FramesSent    = r_frames_sent;
    assign FramesDropped = r_frames_dropped;

endmodule

// File: tb/tb_rvvi_frame_buffer.sv
// tb/tb_rvvi_frame_buffer.sv - directed and table-driven bench for rvvi_frame_buffer
module tb_rvvi_frame_buffer;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] InAxiWdata = '0;
    logic [3:0]  InAxiWstrb = '0;
    logic        InAxiWlast = 1'b0;
    logic        InAxiWvalid = 1'b0;
    logic        InAxiWready;
    logic [31:0] OutAxisTdata;
    logic [3:0]  OutAxisTkeep;
    logic        OutAxisTlast;
    logic        OutAxisTvalid;
    logic        OutAxisTready = 1'b1;
    logic [15:0] FramesPending;
    logic [15:0] FramesSent;
    logic [15:0] FramesDropped;

    int          n_vec = 0;
    int          n_err = 0;
    int          beats = 0;
    logic [36:0] exp_q [$];
    bit          rnd_ready = 1'b0;
    bit          ready_level = 1'b1;

    always #5 clk = ~clk;

    rvvi_frame_buffer #(.DEPTH_LOG2(DL), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .InAxiWdata    (InAxiWdata),
        .InAxiWstrb    (InAxiWstrb),
        .InAxiWlast    (InAxiWlast),
        .InAxiWvalid   (InAxiWvalid),
        .InAxiWready   (InAxiWready),
        .OutAxisTdata  (OutAxisTdata),
        .OutAxisTkeep  (OutAxisTkeep),
        .OutAxisTlast  (OutAxisTlast),
        .OutAxisTvalid (OutAxisTvalid),
        .OutAxisTready (OutAxisTready),
        .FramesPending (FramesPending),
        .FramesSent    (FramesSent),
        .FramesDropped (FramesDropped)
    );

    always @(posedge clk) begin
        #1;
        OutAxisTready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [36:0] prev_word = '0;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", OutAxisTvalid, 1);
                check("stall_word", {OutAxisTdata, OutAxisTkeep, OutAxisTlast}, prev_word);
            end
            if (OutAxisTvalid && OutAxisTready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("beat_word", {OutAxisTdata, OutAxisTkeep, OutAxisTlast}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                beats++;
            end
            prev_stall = OutAxisTvalid && !OutAxisTready;
            prev_word  = {OutAxisTdata, OutAxisTkeep, OutAxisTlast};
        end
    end

    task automatic send_word(input logic [36:0] w, input int budget, input bit chk_sf, output bit ok);
        int t = 0;
        {InAxiWdata, InAxiWstrb, InAxiWlast} = w;
        InAxiWvalid = 1'b1;
        ok = 1'b0;
        while (t < budget) begin
            @(negedge clk);
            if (chk_sf) check("sf_tvalid_low", OutAxisTvalid, 0);
            if (InAxiWready) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        InAxiWvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit gapped, input bit rnd_strb, input bit chk_sf);
        bit          ok;
        bit          keep;
        logic [36:0] w;
        keep = (len <= DEPTH);
        for (int i = 0; i < len; i++) begin
            w = {$urandom(), (rnd_strb ? 4'($urandom()) : 4'hF), (i == len - 1)};
            if (keep) exp_q.push_back(w);
            send_word(w, 5000, chk_sf, ok);
            check("wr_accept", ok, 1);
            if (gapped && (i < len - 1)) begin
                @(negedge clk);
                if (chk_sf) check("sf_tvalid_low", OutAxisTvalid, 0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || OutAxisTvalid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int len;
        bit gapped;
        bit chk_lat;
        int exp_beats;
        int exp_sent;
        int exp_dropped;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          b0;
        int          acc;
        bit          ok;
        int          exp_sent;
        int          exp_drop;
        int          len;
        logic [36:0] w2 [30];

        vecs[0] = '{30,  1'b0, 1'b1, 30, 1, 0};
        vecs[1] = '{20,  1'b1, 1'b0, 20, 2, 0};
        vecs[2] = '{1,   1'b0, 1'b1, 1,  3, 0};
        vecs[3] = '{64,  1'b0, 1'b1, 64, 4, 0};
        vecs[4] = '{65,  1'b0, 1'b0, 0,  4, 1};
        vecs[5] = '{100, 1'b0, 1'b0, 0,  4, 2};
        vecs[6] = '{10,  1'b0, 1'b0, 10, 5, 2};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_wready", InAxiWready, 1);
        check("rst_tvalid", OutAxisTvalid, 0);
        check("rst_tlast", OutAxisTlast, 0);
        check("rst_tdata", OutAxisTdata, 0);
        check("rst_tkeep", OutAxisTkeep, 0);
        check("rst_counters", {FramesPending, FramesSent, FramesDropped}, 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            b0 = beats;
            send_frame(vecs[v].len, vecs[v].gapped, 1'b0, vecs[v].gapped);
            if (vecs[v].chk_lat) begin
                @(negedge clk);
                check("lat_edge1", OutAxisTvalid, 0);
                @(negedge clk);
                check("lat_edge2", OutAxisTvalid, 0);
                @(negedge clk);
                check("lat_edge3", OutAxisTvalid, 1);
            end
            drain("vec");
            check("vec_beats", beats - b0, vecs[v].exp_beats);
            check("vec_sent", FramesSent, vecs[v].exp_sent);
            check("vec_dropped", FramesDropped, vecs[v].exp_dropped);
            check("vec_pending", FramesPending, 0);
        end

        ready_level = 1'b0;
        @(posedge clk);
        #1;
        send_frame(40, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            w2[i] = {$urandom(), 4'($urandom()), (i == 29)};
            exp_q.push_back(w2[i]);
        end
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            send_word(w2[i], 20, 1'b0, ok);
            if (!ok) break;
            acc++;
        end
        check("bp_accepted", 40 + acc, 64);
        check("bp_wready_low", InAxiWready, 0);
        check("bp_dropped", FramesDropped, 2);
        check("bp_pending", FramesPending, 1);
        ready_level = 1'b1;
        for (int i = acc; i < 30; i++) begin
            send_word(w2[i], 5000, 1'b0, ok);
            check("bp_rest_accept", ok, 1);
        end
        drain("bp");
        check("bp_sent", FramesSent, 7);
        check("bp_pending_done", FramesPending, 0);

        exp_sent = 7;
        exp_drop = 2;
        rnd_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(1, 80);
            send_frame(len, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
            if (len <= DEPTH) exp_sent++;
            else exp_drop++;
        end
        drain("rnd");
        rnd_ready = 1'b0;
        check("rnd_sent", FramesSent, 16'(exp_sent));
        check("rnd_dropped", FramesDropped, 16'(exp_drop));
        check("rnd_pending", FramesPending, 0);

        ready_level = 1'b0;
        @(posedge clk);
        #1;
        send_frame(30, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_word({$urandom(), 4'hF, 1'b0}, 5000, 1'b0, ok);
            check("mr_in_accept", ok, 1);
        end
        ready_level = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_wready", InAxiWready, 1);
        check("mr_tvalid", OutAxisTvalid, 0);
        check("mr_tlast", OutAxisTlast, 0);
        check("mr_tdata", OutAxisTdata, 0);
        check("mr_tkeep", OutAxisTkeep, 0);
        check("mr_counters", {FramesPending, FramesSent, FramesDropped}, 0);
        @(posedge clk);
        #1;
        b0 = beats;
        send_frame(12, 1'b0, 1'b1, 1'b0);
        drain("mr");
        check("mr_beats", beats - b0, 12);
        check("mr_sent", FramesSent, 1);
        check("mr_dropped", FramesDropped, 0);
        check("mr_pending", FramesPending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
